// File: rtl/intel_8255.sv
// Mode 0 / BSR subset of the 8255 programmable peripheral interface.
// Register writes are clocked; reads and all tri-state enables are combinational.
module intel_8255 (
    input  logic       CLK,
    inout  wire  [7:0] DATA,
    input  logic       RD,
    input  logic       WR,
    input  logic [1:0] A,
    input  logic       RESET,
    input  logic       CS,
    inout  wire  [7:0] PORTA,
    inout  wire  [7:0] PORTB,
    inout  wire  [7:0] PORTC
);

    typedef enum logic [1:0] {
        SelPortA = 2'b00,
        SelPortB = 2'b01,
        SelPortC = 2'b10,
        SelCtrl  = 2'b11
    } reg_sel_e;

    localparam logic [7:0] CtrlReset = 8'b1001_1011;

    reg_sel_e   sel;
    logic       wr_en;
    logic       rd_en;

    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] la_q, la_d;
    logic [7:0] lb_q, lb_d;
    logic [7:0] lc_q, lc_d;

    logic       pa_in;
    logic       pb_in;
    logic       pcu_in;
    logic       pcl_in;

    logic [7:0] rd_data;
    logic       rd_oe;

    // Mode bits are kept in the control register but every port runs in Mode 0.
    logic       unused_mode_bits;

    assign sel   = reg_sel_e'(A);
    assign wr_en = !CS && !WR && RD;
    assign rd_en = !CS && !RD && WR;

    assign pa_in  = ctrl_q[4];
    assign pb_in  = ctrl_q[1];
    assign pcu_in = ctrl_q[3];
    assign pcl_in = ctrl_q[0];

    assign unused_mode_bits = ^{ctrl_q[7:5], ctrl_q[2]};

    always_comb begin
        ctrl_d = ctrl_q;
        la_d   = la_q;
        lb_d   = lb_q;
        lc_d   = lc_q;
        if (wr_en) begin
            unique case (sel)
                SelPortA: la_d = DATA;
                SelPortB: lb_d = DATA;
                SelPortC: lc_d = DATA;
                SelCtrl: begin
                    if (DATA[7]) begin
                        ctrl_d = DATA;
                        la_d   = 8'h00;
                        lb_d   = 8'h00;
                        lc_d   = 8'h00;
                    end else begin
                        // BSR touches the latch even when the nibble is an input.
                        lc_d[DATA[3:1]] = DATA[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q <= CtrlReset;
            la_q   <= 8'h00;
            lb_q   <= 8'h00;
            lc_q   <= 8'h00;
        end else begin
            ctrl_q <= ctrl_d;
            la_q   <= la_d;
            lb_q   <= lb_d;
            lc_q   <= lc_d;
        end
    end

    assign PORTA      = pa_in  ? 8'hzz : la_q;
    assign PORTB      = pb_in  ? 8'hzz : lb_q;
    assign PORTC[7:4] = pcu_in ? 4'hz  : lc_q[7:4];
    assign PORTC[3:0] = pcl_in ? 4'hz  : lc_q[3:0];

    always_comb begin
        rd_data = 8'h00;
        unique case (sel)
            SelPortA: rd_data = pa_in ? PORTA : la_q;
            SelPortB: rd_data = pb_in ? PORTB : lb_q;
            SelPortC: begin
                rd_data[7:4] = pcu_in ? PORTC[7:4] : lc_q[7:4];
                rd_data[3:0] = pcl_in ? PORTC[3:0] : lc_q[3:0];
            end
            default: rd_data = 8'h00;
        endcase
    end

    // The control register is write-only, so A=11 never enables the bus.
    assign rd_oe = rd_en && (sel != SelCtrl);
    assign DATA  = rd_oe ? rd_data : 8'hzz;

endmodule

// File: tb/tb_intel_8255.sv
// Directed bench for intel_8255: stimulus pushes expected bus/pin values into a
// scoreboard queue, a negedge monitor pops and compares. Pull-ups make high-Z read as FF.
module tb_intel_8255;

    logic       CLK;
    logic       RD;
    logic       WR;
    logic [1:0] A;
    logic       RESET;
    logic       CS;
    wire  [7:0] DATA;
    wire  [7:0] PORTA;
    wire  [7:0] PORTB;
    wire  [7:0] PORTC;

    logic [7:0] d_drv, pa_drv, pb_drv, pc_drv;
    logic       d_en, pa_en, pb_en, pcu_en, pcl_en;

    assign DATA       = d_en   ? d_drv        : 8'hzz;
    assign PORTA      = pa_en  ? pa_drv       : 8'hzz;
    assign PORTB      = pb_en  ? pb_drv       : 8'hzz;
    assign PORTC[7:4] = pcu_en ? pc_drv[7:4]  : 4'hz;
    assign PORTC[3:0] = pcl_en ? pc_drv[3:0]  : 4'hz;

    pullup pu_data (DATA);
    pullup pu_pa (PORTA);
    pullup pu_pb (PORTB);
    pullup pu_pc (PORTC);

    intel_8255 dut (
        .CLK   (CLK),
        .DATA  (DATA),
        .RD    (RD),
        .WR    (WR),
        .A     (A),
        .RESET (RESET),
        .CS    (CS),
        .PORTA (PORTA),
        .PORTB (PORTB),
        .PORTC (PORTC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int SelData = 0;
    localparam int SelPa   = 1;
    localparam int SelPb   = 2;
    localparam int SelPc   = 3;
    localparam int SelCtrl = 4;

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge CLK) begin : monitor
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SelData: obs = DATA;
                SelPa:   obs = PORTA;
                SelPb:   obs = PORTB;
                SelPc:   obs = PORTC;
                default: obs = dut.ctrl_q;
            endcase
            n_checks++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %02h expected %02h", e.name, obs, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input int sel, input logic [7:0] exp, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b0; WR = 1'b0; RD = 1'b1; A = a; d_drv = d; d_en = 1'b1;
        step();
        CS = 1'b1; WR = 1'b1; d_en = 1'b0;
    endtask

    task automatic wr_nocs(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b1; WR = 1'b0; RD = 1'b1; A = a; d_drv = d; d_en = 1'b1;
        step();
        WR = 1'b1; d_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string name);
        CS = 1'b0; RD = 1'b0; WR = 1'b1; A = a; d_en = 1'b0;
        chk(SelData, exp, name);
        step();
        CS = 1'b1; RD = 1'b1;
    endtask

    task automatic ports(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                         input string name);
        chk(SelPa, ea, {name, "_pa"});
        chk(SelPb, eb, {name, "_pb"});
        chk(SelPc, ec, {name, "_pc"});
        step();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] t;
        RESET = 1'b1; CS = 1'b1; RD = 1'b1; WR = 1'b1; A = 2'b00;
        d_drv = 8'h00; pa_drv = 8'h00; pb_drv = 8'h00; pc_drv = 8'h00;
        d_en = 1'b0; pa_en = 1'b0; pb_en = 1'b0; pcu_en = 1'b0; pcl_en = 1'b0;
        step();
        step();
        RESET = 1'b0;

        // Reset state: all inputs, bus idle
        chk(SelCtrl, 8'h9B, "reset_ctrl");
        chk(SelData, 8'hFF, "reset_data_z");
        ports(8'hFF, 8'hFF, 8'hFF, "reset_z");

        // Mode set to all outputs, then port writes
        wr(2'b11, 8'h80);
        ports(8'h00, 8'h00, 8'h00, "mode80");
        wr(2'b00, 8'hFF);
        wr(2'b01, 8'hFF);
        wr(2'b10, 8'hFF);
        ports(8'hFF, 8'hFF, 8'hFF, "wr_ff");
        wr(2'b00, 8'hA5);
        wr(2'b01, 8'h3C);
        wr(2'b10, 8'h69);
        ports(8'hA5, 8'h3C, 8'h69, "wr_pat");
        rd_chk(2'b00, 8'hA5, "rd_la");
        rd_chk(2'b10, 8'h69, "rd_lc");
        wr(2'b11, 8'h80);
        ports(8'h00, 8'h00, 8'h00, "mode80_clear");

        // BSR set bits 0..7, then clear them
        for (int i = 0; i < 8; i++) begin
            wr(2'b11, 8'((i << 1) | 1));
            t = (16'h1 << (i + 1)) - 16'h1;
            chk(SelPc, t[7:0], $sformatf("bsr_set%0d", i));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            wr(2'b11, 8'(i << 1));
            t = 16'h00FF << (i + 1);
            chk(SelPc, t[7:0], $sformatf("bsr_clr%0d", i));
            step();
        end

        // All inputs: reads return pins, control not readable
        wr(2'b11, 8'h9B);
        pa_drv = 8'd13; pb_drv = 8'h33; pc_drv = 8'h55;
        pa_en = 1'b1; pb_en = 1'b1; pcu_en = 1'b1; pcl_en = 1'b1;
        rd_chk(2'b00, 8'h0D, "rd_pa_pin");
        rd_chk(2'b01, 8'h33, "rd_pb_pin");
        rd_chk(2'b10, 8'h55, "rd_pc_pin");
        rd_chk(2'b11, 8'hFF, "rd_ctrl_z");
        pa_en = 1'b0; pb_en = 1'b0; pcu_en = 1'b0; pcl_en = 1'b0;
        step();

        // A/B output, C input
        wr(2'b11, 8'h89);
        wr(2'b10, 8'hAA);
        pc_drv = 8'h5A; pcu_en = 1'b1; pcl_en = 1'b1;
        ports(8'h00, 8'h00, 8'h5A, "ctl89");
        rd_chk(2'b10, 8'h5A, "rd_pc_in");
        pcu_en = 1'b0; pcl_en = 1'b0;
        step();

        // Split port C: upper input, lower output
        wr(2'b11, 8'h88);
        wr(2'b10, 8'h3C);
        pc_drv = 8'h90; pcu_en = 1'b1;
        chk(SelPc, 8'h9C, "split_pc_pins");
        step();
        rd_chk(2'b10, 8'h9C, "rd_pc_split");
        pcu_en = 1'b0;
        step();

        // Chip not selected: writes ignored, bus never driven
        wr(2'b11, 8'h9B);
        wr_nocs(2'b11, 8'h80);
        wr_nocs(2'b00, 8'hFF);
        ports(8'hFF, 8'hFF, 8'hFF, "cs_hi_wr");
        chk(SelCtrl, 8'h9B, "cs_hi_ctrl");
        step();
        wr(2'b11, 8'h80);
        CS = 1'b1; RD = 1'b0; A = 2'b00;
        chk(SelData, 8'hFF, "cs_hi_rd_z");
        step();
        RD = 1'b1;

        // RD and WR both low: no write, no drive
        wr(2'b11, 8'h9B);
        CS = 1'b0; RD = 1'b0; WR = 1'b0; A = 2'b11; d_drv = 8'h80; d_en = 1'b1;
        step();
        CS = 1'b1; RD = 1'b1; WR = 1'b1; d_en = 1'b0;
        ports(8'hFF, 8'hFF, 8'hFF, "rdwr_both");

        // Level-sampled write: last DATA wins, A change retargets
        wr(2'b11, 8'h80);
        CS = 1'b0; WR = 1'b0; RD = 1'b1; A = 2'b00; d_drv = 8'h77; d_en = 1'b1;
        step();
        d_drv = 8'h11;
        step();
        A = 2'b01; d_drv = 8'h22;
        step();
        CS = 1'b1; WR = 1'b1; d_en = 1'b0;
        ports(8'h11, 8'h22, 8'h00, "level_wr");

        // Reset beats a simultaneous control write
        wr(2'b11, 8'h9B);
        CS = 1'b0; WR = 1'b0; A = 2'b11; d_drv = 8'h80; d_en = 1'b1; RESET = 1'b1;
        step();
        CS = 1'b1; WR = 1'b1; d_en = 1'b0; RESET = 1'b0;
        chk(SelCtrl, 8'h9B, "rst_prio_ctrl");
        ports(8'hFF, 8'hFF, 8'hFF, "rst_prio");

        // Reset mid-write from an output configuration
        wr(2'b11, 8'h80);
        CS = 1'b0; WR = 1'b0; A = 2'b00; d_drv = 8'h5A; d_en = 1'b1; RESET = 1'b1;
        step();
        CS = 1'b1; WR = 1'b1; d_en = 1'b0; RESET = 1'b0;
        chk(SelCtrl, 8'h9B, "rst_mid_ctrl");
        ports(8'hFF, 8'hFF, 8'hFF, "rst_mid");
        wr(2'b11, 8'h80);
        ports(8'h00, 8'h00, 8'h00, "rst_mid_latch");

        step();
        step();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intel_8255.md
# intel_8255

Programmable peripheral interface modelled on the Intel 8255. It supports Mode 0 basic I/O on three 8-bit bidirectional ports (A, B, C) and Bit Set/Reset (BSR) on port C. It sits between a processor-style 8-bit data bus and external peripheral pins. Register writes are sampled on the clock; reads are combinational.

## Interface
- No parameters.
- Port order: CLK, DATA, RD, WR, A, RESET, CS, PORTA, PORTB, PORTC.
- CLK  input  1  single system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA  inout  8  processor data bus; high-Z unless a read is active.
- RD  input  1  active-low read strobe.
- WR  input  1  active-low write strobe.
- A  input  2  register select: 00 = port A, 01 = port B, 10 = port C, 11 = control.
- CS  input  1  active-low chip select.
- PORTA  inout  8  peripheral port A.
- PORTB  inout  8  peripheral port B.
- PORTC  inout  8  peripheral port C; upper nibble PC7–4 and lower nibble PC3–0 have independent directions.

## Operation
- State:
  - control register CTRL[7:0]
  - output latches LA, LB, LC (8 bits each)
- Write cycle: CS=0, WR=0, RD=1.
- Read cycle: CS=0, RD=0, WR=1.
- Any other strobe combination, including RD=WR=0 or CS=1: no state change, DATA high-Z.
- Write with A=11 and DATA[7]=1 (mode set):
  - CTRL <= DATA.
  - LA, LB, LC <= 0.
  - Direction bits (1 = input, 0 = output): D4 = port A, D1 = port B, D3 = PC7–4, D0 = PC3–0.
  - Mode bits D6:5 and D2 are stored but ignored; every port operates in Mode 0.
- Write with A=11 and DATA[7]=0 (BSR):
  - LC[DATA[3:1]] <= DATA[0]. All other bits and CTRL are unchanged.
  - The latch updates regardless of port C direction; the pin reflects the bit only if its nibble is an output.
- Write with A=00/01/10: LA, LB or LC <= DATA respectively, regardless of direction.
- Pin drive:
  - PORTA is driven with LA when port A is an output, otherwise high-Z. PORTB likewise with LB.
  - Each PORTC nibble is driven from the matching LC nibble when that nibble is an output, otherwise high-Z.
- Read (combinational):
  - A=00: DATA = PORTA pins if port A is an input, else LA.
  - A=01: same rule for port B / LB.
  - A=10: per nibble, pin value if that nibble is an input, else the LC nibble.
  - A=11: DATA stays high-Z (the control register is not readable).

## Timing
- RESET=1 at a rising edge:
  - CTRL <= 8'b1001_1011 (all ports input, Mode 0).
  - LA, LB, LC <= 0.
  - All port pins and DATA become high-Z.
- RESET has priority over a simultaneous write.
- Write latency: state updates at the first rising edge where the write condition holds. Pin changes appear after that edge.
- Writes are level-sampled. A strobe held low across N edges writes N times, so the last sampled DATA/A wins. Changing A while WR stays low retargets subsequent edges.
- A direction change takes effect on pins immediately after the control-word edge. Latches are cleared by the same edge.
- DATA enable and port read values are combinational on CS/RD/WR/A and pin inputs; no clock latency.
- Reset asserted mid-write: the write is discarded.

## Test plan
- Reset, then idle with CS=1 → CTRL = 0x9B; PORTA/B/C = Z; DATA = Z.
- Control 0x80, then write 0xFF to A=00, 01, 10, one edge each → PORTA = PORTB = PORTC = 0xFF; a subsequent control 0x80 write returns all three ports to 0x00.
- Control 0x80, then BSR writes 0x01, 0x03, …, 0x0F → PORTC goes 0x01, 0x03, … up to 0xFF; BSR writes 0x00, 0x02, …, 0x0E → PORTC clears back to 0x00 bit by bit.
- Control 0x9B; drive PORTA=13, PORTB=0x33, PORTC=0x55 externally; read with A=00/01/10 → DATA = 0x0D, 0x33, 0x55; read with A=11 → DATA = Z.
- Control 0x89 (A and B output, C input); write LC=0xAA; drive PORTC=0x5A → PORTC pins not driven by the chip; read A=10 → 0x5A.
- CS=1 while writing control 0x80 and data 0xFF → no change; ports remain Z; DATA never driven by the chip.
